// File: rtl/aes_enc_round_ctrl_pkg.sv
// Shared types and constants for the iterative AES encryption sequencer.
// Blocks are 128-bit vectors; byte 0 is the most significant byte and bytes are in column-major state order.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W  = 128;
  localparam int unsigned AES_NR_128   = 10;
  localparam int unsigned AES_RK_IDX_W = 4;

  typedef logic [AES_BLOCK_W-1:0]  block_t;
  typedef logic [AES_RK_IDX_W-1:0] rnd_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round_ctrl_if.sv
// Block I/O, key-store and status bundle for aes_enc_round_ctrl.
// slave is the controller side, master is the wrapper/key-store side.
interface aes_enc_round_ctrl_if #(
  parameter int unsigned RK_IDX_W = 4
);
  import aes_pkg::*;

  logic                in_valid;
  logic                in_ready;
  block_t              in_data;
  logic [RK_IDX_W-1:0] rk_idx;
  block_t              rk;
  logic                out_valid;
  logic                out_ready;
  block_t              out_data;
  logic                busy;

  modport master (
    output in_valid, in_data, rk, out_ready,
    input  in_ready, rk_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, rk, out_ready,
    output in_ready, rk_idx, out_valid, out_data, busy
  );

endinterface

// File: rtl/aes_enc_round_ctrl_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped when final_rnd), AddRoundKey.
// Also holds the three transform modules the round is built from.
module subBytes
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout_c
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 via a short addition chain, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = x15;
    for (int i = 0; i < 4; i++) x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign dout_c[127-8*i -: 8] = sbox(din[127-8*i -: 8]);
  end

endmodule

module shiftRows
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout_c
);

  // Row r of column c takes the byte from column (c+r) mod 4
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dout_c[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

endmodule

module mixColumns
  import aes_pkg::*;
(
  input  block_t din,
  output block_t dout_c
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[127-32*c -: 8];
    assign a1 = din[119-32*c -: 8];
    assign a2 = din[111-32*c -: 8];
    assign a3 = din[103-32*c -: 8];
    assign dout_c[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign dout_c[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign dout_c[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign dout_c[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

module aes_round
  import aes_pkg::*;
(
  input  block_t st,
  input  block_t rk,
  input  logic   final_rnd,
  output block_t nxt_c
);

  block_t sb_c, sr_c, mc_c;

  subBytes   u_sub   (.din(st),   .dout_c(sb_c));
  shiftRows  u_shift (.din(sb_c), .dout_c(sr_c));
  mixColumns u_mix   (.din(sr_c), .dout_c(mc_c));

  assign nxt_c = (final_rnd ? sr_c : mc_c) ^ rk;

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES encryption sequencer: one shared round per clock, round keys fetched by index.
// Define AES_BACK2BACK_EN to accept a new block in the same cycle the ciphertext is consumed.
module aes_enc_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR       = AES_NR_128,
  parameter int unsigned RK_IDX_W = AES_RK_IDX_W
) (
  input logic                 clk,
  input logic                 rst,
  aes_enc_round_ctrl_if.slave bus
);

  localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(NR);
  localparam logic [RK_IDX_W-1:0] RND_ONE = RK_IDX_W'(1);

  aes_state_e          state, state_nx;
  logic [RK_IDX_W-1:0] rnd, rnd_nx;
  block_t              st, st_nx;
  block_t              round_c;
  logic                final_rnd_c;

  assign final_rnd_c = (rnd == NR_IDX);

  aes_round u_round (
    .st       (st),
    .rk       (bus.rk),
    .final_rnd(final_rnd_c),
    .nxt_c    (round_c)
  );

  // State register, round counter and data state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
      st    <= '0;
    end else begin
      state <= state_nx;
      rnd   <= rnd_nx;
      st    <= st_nx;
    end
  end

  // Next state, counter and data
  always_comb begin
    state_nx = state;
    rnd_nx   = rnd;
    st_nx    = st;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          st_nx    = bus.in_data ^ bus.rk;
          rnd_nx   = RND_ONE;
          state_nx = ROUND;
        end
      end
      ROUND: begin
        // Counter outside 1..NR cannot occur; recover to IDLE if it ever does
        if (rnd == '0 || rnd > NR_IDX) begin
          rnd_nx   = '0;
          state_nx = IDLE;
        end else begin
          st_nx = round_c;
          if (final_rnd_c) begin
            rnd_nx   = '0;
            state_nx = DONE;
          end else begin
            rnd_nx = rnd + RND_ONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
`ifdef AES_BACK2BACK_EN
          if (bus.in_valid) begin
            st_nx    = bus.in_data ^ bus.rk;
            rnd_nx   = RND_ONE;
            state_nx = ROUND;
          end else begin
            state_nx = IDLE;
          end
`else
          state_nx = IDLE;
`endif
        end
      end
      default: begin
        rnd_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Handshake and status decode from the registered state
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.rk_idx    = '0;
    unique case (state)
      IDLE:  bus.in_ready = 1'b1;
      ROUND: begin
        bus.busy   = 1'b1;
        bus.rk_idx = rnd;
      end
      DONE: begin
        bus.out_valid = 1'b1;
`ifdef AES_BACK2BACK_EN
        bus.in_ready  = bus.out_ready;
`endif
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  assign bus.out_data = st;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Self-checking bench for aes_enc_round_ctrl: FIPS-197 vectors, backpressure, mid-block reset,
// random blocks against a byte-level AES model, and back-to-back timing.
module tb_aes_enc_round_ctrl #(
  parameter int unsigned NR = 10
);

  localparam int unsigned RKW = 4;
  localparam int          NK  = int'(NR) - 6;
  localparam int          NW  = 4 * (int'(NR) + 1);
`ifdef AES_BACK2BACK_EN
  localparam int          B2B = 1;
`else
  localparam int          B2B = 0;
`endif

  localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_enc_round_ctrl_if #(.RK_IDX_W(RKW)) bus ();

  aes_enc_round_ctrl #(.NR(NR), .RK_IDX_W(RKW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [127:0] rk_tab [0:15];
  logic [7:0]   sbox   [0:255];
  int           n_tests = 0;
  int           n_fail  = 0;

  // External key store: combinational lookup by index
  assign bus.rk = rk_tab[bus.rk_idx];

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box from walking the generator 3 and its inverse in lock-step
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Key expansion for AES-128/192/256 selected by NR; key bytes are taken from the top of 'key'
  task automatic expand(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < NK; i++) w[i] = key[255-32*i -: 32];
    rcon = 8'h01;
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) begin
        t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (NK > 6 && i % NK == 4) begin
        t = subw(t);
      end
      w[i] = w[i-NK] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_tab[r] = (r <= int'(NR)) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Byte-array AES encryption using the current key table
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk_tab[0][127-8*i -: 8];
    for (int r = 1; r <= int'(NR); r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[w+4*c] = sbox[s[w+4*((c+w)%4)]];
      if (r != int'(NR)) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk_tab[r][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] kat_ct();
    case (NR)
      12:      return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      14:      return 128'h8ea2b7ca516745bfeafc49904b496089;
      default: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    endcase
  endfunction

  // Offer one block, follow it through the rounds, hold the result 'hold' cycles, then consume it
  task automatic run_block(input logic [127:0] pt, input int hold, input logic [127:0] exp,
                           input string tag);
    int           k, lat;
    bit           seq_ok, bp_ok;
    logic [127:0] got;
    bus.in_valid = 1'b1;
    bus.in_data  = pt;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk_eq({tag, " in_ready"}, bus.in_ready, 1);
    chk_eq({tag, " rk_idx at accept"}, bus.rk_idx, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
    lat    = 1;
    seq_ok = 1'b1;
    while (!bus.out_valid && lat < 64) begin
      if (bus.rk_idx != RKW'(lat) || !bus.busy || bus.in_ready) seq_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk_eq({tag, " latency"}, lat, NR + 1);
    chk_eq({tag, " rk_idx sequence"}, seq_ok, 1);
    got = bus.out_data;
    chk_eq({tag, " ciphertext"}, got, exp);
    bp_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== got || bus.in_ready || bus.busy || bus.rk_idx != '0)
        bp_ok = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (hold > 0) chk_eq({tag, " held under backpressure"}, bp_ok, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk_eq({tag, " idle after consume {ov,ir,busy}"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
  endtask

  // Two blocks with in_valid held high and out_ready always asserted
  task automatic b2b_test();
    int           t, acc, outs;
    int           acc_t [0:1];
    int           out_t [0:1];
    logic [127:0] d     [0:1];
    logic [127:0] e0, e1;
    expand(KAT_KEY);
    e0 = aes_ref(KAT_PT);
    e1 = aes_ref(B_PT);
    acc = 0; outs = 0; t = 0;
    acc_t[0] = -1; acc_t[1] = -1; out_t[0] = -1; out_t[1] = -1;
    d[0] = '0; d[1] = '0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = KAT_PT;
    bus.out_ready = 1'b1;
    #1;
    while (t < 40 && outs < 2) begin
      if (bus.in_valid && bus.in_ready && acc < 2) begin
        acc_t[acc] = t;
        acc++;
      end
      if (bus.out_valid) begin
        out_t[outs] = t;
        d[outs]     = bus.out_data;
        outs++;
      end
      @(negedge clk);
      t++;
      if (acc == 1) bus.in_data = B_PT;
      else if (acc == 2) bus.in_valid = 1'b0;
      #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk_eq("b2b first output cycle", out_t[0], NR + 1);
    chk_eq("b2b second accept cycle", acc_t[1], int'(NR) + 2 - B2B);
    chk_eq("b2b second output cycle", out_t[1], 2 * int'(NR) + 3 - B2B);
    chk_eq("b2b first ciphertext", d[0], e0);
    chk_eq("b2b second ciphertext", d[1], e1);
  endtask

  initial begin
    int           k;
    bit           quiet;
    logic [255:0] key;
    logic [127:0] pt;

    build_sbox();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    expand(KAT_KEY);
    repeat (2) @(negedge clk);
    chk_eq("reset {in_ready,out_valid,busy}", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    chk_eq("reset rk_idx", bus.rk_idx, 0);
    chk_eq("reset out_data", bus.out_data, 0);
    rst = 1'b0;

    // Known-answer vector for the configured key length
    run_block(KAT_PT, 0, kat_ct(), "kat");

    // Appendix B vector, held 20 cycles against backpressure
    expand({B_KEY, 128'h0});
    run_block(B_PT, 20, (NR == 10) ? B_CT : aes_ref(B_PT), "appB");

    // Reset in the middle of round 5
    expand(KAT_KEY);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = KAT_PT;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (bus.rk_idx != RKW'(5) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk_eq("midreset reached round 5", bus.rk_idx, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_eq("midreset {out_valid,in_ready,busy}", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
    chk_eq("midreset rk_idx", bus.rk_idx, 0);
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) quiet = 1'b0;
    end
    chk_eq("midreset no partial output", quiet, 1);
    run_block(KAT_PT, 0, kat_ct(), "kat after reset");

    // Random keys and plaintexts against the model
    for (int n = 0; n < 12; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand(key);
      run_block(pt, $urandom_range(0, 3), aes_ref(pt), $sformatf("rand%0d", n));
    end

    b2b_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_enc_round_ctrl.md
Name: aes_enc_round_ctrl

Overview:
Iterative AES encryption sequencer that shares one round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) across all rounds, one round per clock. It accepts a 128-bit plaintext block over a valid/ready handshake and selects round keys by index from an external key store. It returns the ciphertext over a second valid/ready handshake. It sits between the block-level I/O wrapper and the combinational round transforms.

Parameters:
NR, 10, number of rounds; legal values 10, 12 and 14 (AES-128/192/256); key length is handled by the external key store.
RK_IDX_W, 4, width of the round-key index; must satisfy 2^RK_IDX_W > NR.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  plaintext block offered.
in_ready  output  1  block can be accepted this cycle.
in_data  input  [0:127]  plaintext; byte 0 at bits [0:7]; column-major state order (bytes 0-3 = column 0).
rk_idx  output  [RK_IDX_W-1:0]  index of the round key required this cycle.
rk  input  [0:127]  round key for rk_idx; combinationally valid in the same cycle.
out_valid  output  1  ciphertext available.
out_ready  input  1  consumer accepts ciphertext.
out_data  output  [0:127]  ciphertext, same byte order as in_data.
busy  output  1  high in ROUND state.

Behaviour:
- State register st[0:127], round counter rnd (RK_IDX_W bits), FSM with states IDLE, ROUND, DONE.
- Reset values: FSM=IDLE, rnd=0, st=0, in_ready=1, out_valid=0, busy=0, rk_idx=0. out_data mirrors st, so it reads 0 after reset.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid: st <= in_data ^ rk (initial AddRoundKey), rnd <= 1, go to ROUND.
- ROUND:
  - in_ready=0, busy=1, rk_idx=rnd.
  - Each cycle: st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), rk).
  - When rnd==NR, MixColumns is bypassed (final round) and the FSM goes to DONE; otherwise rnd <= rnd+1.
  - in_valid is ignored in this state.
- DONE:
  - out_valid=1, out_data=st; st and out_data are held stable until out_ready.
  - On out_ready: out_valid drops the next cycle and the FSM returns to IDLE.
  - rk_idx=0 in this state.
- Latency: a handshake on cycle 0 gives out_valid on cycle NR+1 (11 for NR=10). Throughput is one block per NR+2 cycles without the optional feature.
- Backpressure: out_valid may stay high indefinitely. No data is lost and no new input is accepted while out_valid is high.
- Reset mid-operation: the block being processed is discarded, all outputs return to reset values on the next edge, and no partial ciphertext is emitted.
- rnd never exceeds NR; there is no wrap-around. A counter value outside 1..NR in ROUND is unreachable, and an implementation may map it to IDLE.
- in_data is sampled only on the accepting edge; changes to it at other times have no effect.

Optional Feature:
AES_BACK2BACK_EN:
- Defined: in DONE, in_ready = out_ready.
  - If out_valid&out_ready&in_valid occur in the same cycle, the ciphertext is consumed and the new block is loaded (st <= in_data ^ rk, with rk_idx=0, rnd <= 1). The FSM goes directly to ROUND.
  - Throughput becomes one block per NR+1 cycles.
- Undefined: in_ready=0 in DONE, and behaviour is exactly as described above.

Decomposition:
- Package aes_pkg holds:
  - typedef of the state enum (IDLE, ROUND, DONE);
  - a 128-bit block type;
  - constants AES_BLOCK_W=128 and AES_NR_128=10;
  - a round-index type.
- One natural sub-module, aes_round: combinational SubBytes → ShiftRows → MixColumns (bypassed by input final_rnd) → XOR rk.
  - It instantiates the existing subBytes, shiftRows and mixColumns modules.
  - The controller owns only the FSM, counter, state register and handshakes.

Test Plan:
- FIPS-197 C.1: pt 00112233445566778899aabbccddeeff with key-schedule table from key 000102030405060708090a0b0c0d0e0f -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 11 cycles after acceptance.
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c -> 3925841d02dc09fbdc118597196a0b32. Check the rk_idx sequence 0,1,...,10 on consecutive cycles.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out_data stable, in_ready=0 throughout, in_valid pulses ignored. Releasing out_ready gives IDLE one cycle later.
- Reset at rnd=5: assert rst for one cycle -> next cycle out_valid=0, in_ready=1, busy=0, rk_idx=0. A fresh C.1 block then produces the correct ciphertext.
- Back-to-back with AES_BACK2BACK_EN, sending C.1 then App. B with in_valid held high:
  - second block accepted in the cycle the first is consumed;
  - outputs on cycles 11 and 22;
  - without the macro, outputs on cycles 11 and 23.
- NR=14 build with an AES-256 key table (FIPS-197 C.3, key 00..1f) -> 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
